// File: rtl/device2_tx_if.sv
// Parallel push side and serial/status side of the device2 two-lane transmitter.
interface device2_tx_if;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       write1;
    logic       write2;
    logic       out1;
    logic       out2;
    logic       valid1;
    logic       valid2;
    logic       almost_full_f1;
    logic       almost_full_f2;
    logic       err1;
    logic       err2;
    logic       active;

    modport master (
        output in1, in2, write1, write2,
        input  out1, out2, valid1, valid2,
        input  almost_full_f1, almost_full_f2, err1, err2, active
    );

    modport slave (
        input  in1, in2, write1, write2,
        output out1, out2, valid1, valid2,
        output almost_full_f1, almost_full_f2, err1, err2, active
    );
endinterface

// File: rtl/device2_tx.sv
// Two-lane byte-aligned serializer: per-lane push FIFO, shared bit counter and
// SYNC/ACTIVE sequencer that sends an idle preamble before any data.
module device2_tx #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned ALMOST_FULL_TH = 3,
    parameter logic [7:0]  IDLE_BYTE      = 8'hBC,
    parameter int unsigned SYNC_BYTES     = 4
) (
    input  logic         clk,
    input  logic         reset,
    device2_tx_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SYNC_W = $clog2(SYNC_BYTES + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BYTES);
    localparam logic [SYNC_W-1:0] SYNC_ONE  = SYNC_W'(1);

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_bit_cnt;
    logic [SYNC_W-1:0]   r_sync_cnt;
    logic                r_active;
    logic                w_boundary;
    logic                w_sync_load;
    logic                w_load_data;

    logic [7:0]          w_in  [2];
    logic [1:0]          w_wr;
    logic [1:0]          w_out;
    logic [1:0]          w_valid;
    logic [1:0]          w_af;
    logic [1:0]          w_err;

    assign w_in[0]    = bus.in1;
    assign w_in[1]    = bus.in2;
    assign w_wr       = {bus.write2, bus.write1};
    assign w_boundary = (r_bit_cnt == 3'd7);

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer next state: leave SYNC on the boundary after the last idle byte.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SYNC: begin
                if (w_boundary && (r_sync_cnt == SYNC_LAST)) begin
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_state_next = ST_SYNC;
                end
            end
            ST_ACTIVE: w_state_next = ST_ACTIVE;
            default:   w_state_next = ST_SYNC;
        endcase
    end

    // Sequencer outputs: the exiting SYNC boundary already performs a data load.
    always_comb begin
        w_sync_load = 1'b0;
        w_load_data = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_boundary) begin
                    if (r_sync_cnt == SYNC_LAST) begin
                        w_load_data = 1'b1;
                    end else begin
                        w_sync_load = 1'b1;
                    end
                end else begin
                    w_sync_load = 1'b0;
                    w_load_data = 1'b0;
                end
            end
            ST_ACTIVE: w_load_data = w_boundary;
            default: begin
                w_sync_load = 1'b0;
                w_load_data = 1'b0;
            end
        endcase
    end

    // Shared bit counter, preamble counter and active flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt  <= 3'd7;
            r_sync_cnt <= {SYNC_W{1'b0}};
            r_active   <= 1'b0;
        end else begin
            r_bit_cnt <= w_boundary ? 3'd0 : (r_bit_cnt + 3'd1);
            if (w_sync_load) begin
                r_sync_cnt <= r_sync_cnt + SYNC_ONE;
            end
            if (w_load_data) begin
                r_active <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [7:0]       r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0] r_count;
        logic [CNT_W-1:0] w_count_next;
        logic             w_full;
        logic             w_empty;
        logic             w_push;
        logic             w_pop;
        logic [7:0]       r_shift;
        logic             r_valid;
        logic             r_af;
        logic             r_err;

        // Push/pop decisions use the pre-edge count, so a full FIFO drops even while popping.
        always_comb begin
            w_full  = (r_count == CNT_FULL);
            w_empty = (r_count == CNT_ZERO);
            w_push  = w_wr[g] & ~w_full;
            w_pop   = w_load_data & ~w_empty;
            if (w_push && !w_pop) begin
                w_count_next = r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                w_count_next = r_count - CNT_ONE;
            end else begin
                w_count_next = r_count;
            end
        end

        // FIFO storage; contents are discarded on reset through the pointers.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in[g];
            end
        end

        // FIFO pointers, occupancy and status flags.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wr_ptr <= {PTR_W{1'b0}};
                r_rd_ptr <= {PTR_W{1'b0}};
                r_count  <= CNT_ZERO;
                r_af     <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                r_count <= w_count_next;
                r_af    <= (w_count_next >= CNT_AF);
                if (w_wr[g] && w_full) begin
                    r_err <= 1'b1;
                end
            end
        end

        // Serializer: load at byte boundaries, shift MSB-first otherwise.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_shift <= 8'h00;
                r_valid <= 1'b0;
            end else if (w_boundary) begin
                if (w_pop) begin
                    r_shift <= r_mem[r_rd_ptr];
                    r_valid <= 1'b1;
                end else begin
                    r_shift <= IDLE_BYTE;
                    r_valid <= 1'b0;
                end
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end

        assign w_out[g]   = r_shift[7];
        assign w_valid[g] = r_valid;
        assign w_af[g]    = r_af;
        assign w_err[g]   = r_err;
    end

    assign bus.out1           = w_out[0];
    assign bus.out2           = w_out[1];
    assign bus.valid1         = w_valid[0];
    assign bus.valid2         = w_valid[1];
    assign bus.almost_full_f1 = w_af[0];
    assign bus.almost_full_f2 = w_af[1];
    assign bus.err1           = w_err[0];
    assign bus.err2           = w_err[1];
    assign bus.active         = r_active;
endmodule

// File: tb/tb_device2_tx.sv
// Directed self-checking bench for device2_tx: preamble, data latency, FIFO
// overflow, idle interleave, mid-byte reset and same-edge push/pop.
module tb_device2_tx;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    device2_tx_if bus ();

    device2_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] all_outs();
        return {bus.out1, bus.out2, bus.valid1, bus.valid2, bus.almost_full_f1,
                bus.almost_full_f2, bus.err1, bus.err2, bus.active};
    endfunction

    // Starts just after a boundary edge; optional writes land on the next edge.
    task automatic byte_chk(input string tag,
                            input logic w1, input logic [7:0] d1,
                            input logic w2, input logic [7:0] d2,
                            input logic [7:0] e1, input logic ev1,
                            input logic [7:0] e2, input logic ev2);
        logic [7:0] b1;
        logic [7:0] b2;
        logic       v1;
        logic       v2;
        logic       stable;
        b1 = 8'h00;
        b2 = 8'h00;
        v1 = bus.valid1;
        v2 = bus.valid2;
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b1 = {b1[6:0], bus.out1};
            b2 = {b2[6:0], bus.out2};
            if ((bus.valid1 !== v1) || (bus.valid2 !== v2)) stable = 1'b0;
            if (i < 7) begin
                if (i == 0) begin
                    bus.write1 = w1;
                    bus.in1    = d1;
                    bus.write2 = w2;
                    bus.in2    = d2;
                end
                step();
                if (i == 0) begin
                    bus.write1 = 1'b0;
                    bus.write2 = 1'b0;
                end
            end
        end
        check_val({tag, "_b1"}, {24'h0, b1}, {24'h0, e1});
        check_val({tag, "_v1"}, {31'h0, v1}, {31'h0, ev1});
        check_val({tag, "_b2"}, {24'h0, b2}, {24'h0, e2});
        check_val({tag, "_v2"}, {31'h0, v2}, {31'h0, ev2});
        check_val({tag, "_vstable"}, {31'h0, stable}, 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b0;
        n_checks   = 0;
        n_fail     = 0;
        bus.in1    = 8'hFF;
        bus.in2    = 8'hFF;
        bus.write1 = 1'b1;
        bus.write2 = 1'b1;

        // Reset state, with writes held during reset that must be ignored.
        repeat (3) step();
        check_val("reset_outs", {23'h0, all_outs()}, 32'h0);
        bus.write1 = 1'b0;
        bus.write2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Preamble and first data bytes A5/3C written at edge 10.
        step();
        byte_chk("pre0", 1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);
        check_val("pre0_active", {31'h0, bus.active}, 32'h0);
        step();
        byte_chk("pre1", 1'b1, 8'hA5, 1'b1, 8'h3C, 8'hBC, 1'b0, 8'hBC, 1'b0);
        step();
        byte_chk("pre2", 1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);
        step();
        byte_chk("pre3", 1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);
        check_val("edge32_active", {31'h0, bus.active}, 32'h0);
        step();
        check_val("edge33_active", {31'h0, bus.active}, 32'h1);
        byte_chk("data", 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1, 8'h3C, 1'b1);
        step();
        byte_chk("after", 1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);

        // Overflow during SYNC: five pushes into a four-deep FIFO.
        do_reset();
        step();
        for (int k = 0; k < 5; k++) begin
            bus.write1 = 1'b1;
            bus.in1    = 8'(k + 1);
            step();
            check_val($sformatf("af1_push%0d", k + 1), {31'h0, bus.almost_full_f1}, (k >= 2) ? 32'h1 : 32'h0);
            check_val($sformatf("err1_push%0d", k + 1), {31'h0, bus.err1}, (k == 4) ? 32'h1 : 32'h0);
        end
        bus.write1 = 1'b0;
        repeat (26) step();
        check_val("ovf_active_pre", {31'h0, bus.active}, 32'h0);
        check_val("ovf_err2", {31'h0, bus.err2}, 32'h0);
        step();
        check_val("ovf_af1_cnt3", {31'h0, bus.almost_full_f1}, 32'h1);
        byte_chk("ovf01", 1'b0, 8'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'hBC, 1'b0);
        step();
        byte_chk("ovf02", 1'b0, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1, 8'hBC, 1'b0);
        check_val("ovf_af1_cnt2", {31'h0, bus.almost_full_f1}, 32'h0);
        step();
        byte_chk("ovf03", 1'b0, 8'h00, 1'b0, 8'h00, 8'h03, 1'b1, 8'hBC, 1'b0);
        step();
        byte_chk("ovf04", 1'b0, 8'h00, 1'b0, 8'h00, 8'h04, 1'b1, 8'hBC, 1'b0);
        step();
        byte_chk("ovf_idle", 1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);

        // Lane 2 written every 16 cycles: data and idle bytes alternate.
        for (int i = 0; i < 4; i++) begin
            step();
            if ((i % 2) == 0) begin
                byte_chk($sformatf("alt%0d", i), 1'b0, 8'h00, 1'b1, 8'(8'h50 + i),
                         8'hBC, 1'b0, 8'hBC, 1'b0);
            end else begin
                byte_chk($sformatf("alt%0d", i), 1'b0, 8'h00, 1'b0, 8'h00,
                         8'hBC, 1'b0, 8'(8'h50 + i - 1), 1'b1);
            end
        end

        // Reset at bit_cnt==3 with words queued on both lanes.
        step();
        bus.write1 = 1'b1;
        bus.in1    = 8'h77;
        bus.write2 = 1'b1;
        bus.in2    = 8'h88;
        step();
        bus.write1 = 1'b0;
        bus.write2 = 1'b0;
        step();
        step();
        check_val("prerst_err1", {31'h0, bus.err1}, 32'h1);
        reset = 1'b0;
        #1;
        check_val("midrst_outs", {23'h0, all_outs()}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            byte_chk($sformatf("rpre%0d", i), 1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);
        end
        check_val("rpre_active", {31'h0, bus.active}, 32'h0);
        step();
        check_val("ract_active", {31'h0, bus.active}, 32'h1);
        byte_chk("rlost", 1'b1, 8'h11, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);

        // Count==1 and a push on the boundary edge that pops.
        bus.write1 = 1'b1;
        bus.in1    = 8'h22;
        step();
        bus.write1 = 1'b0;
        byte_chk("same11", 1'b0, 8'h00, 1'b0, 8'h00, 8'h11, 1'b1, 8'hBC, 1'b0);
        step();
        byte_chk("same22", 1'b0, 8'h00, 1'b0, 8'h00, 8'h22, 1'b1, 8'hBC, 1'b0);
        step();
        byte_chk("same_idle", 1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 8'hBC, 1'b0);
        check_val("final_err1", {31'h0, bus.err1}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/device2_tx.md
Name: device2_tx

Overview:
- Two-lane parallel-to-serial transmitter. It is the sending end of the serial link that the device2 receiver deserializes.
- Each lane accepts 8-bit words through a push interface into a small FIFO. Each lane serializes one bit per clk, MSB first.
- When a lane has no data, it sends IDLE_BYTE. After reset, both lanes send a fixed idle preamble so the receiver can align before data flows.

Parameters:
- FIFO_DEPTH, 4, words per lane FIFO (power of 2, 2..16).
- ALMOST_FULL_TH, 3, occupancy at or above which almost_full_fN asserts.
- IDLE_BYTE, 8'hBC, byte sent when the lane is idle or in sync.
- SYNC_BYTES, 4, idle bytes sent on both lanes after reset before data may be sent.

Ports:
- clk, input, 1, single clock; all logic rises on posedge.
- reset, input, 1, asynchronous, active-low reset.
- in1, input, 8, lane 1 parallel data.
- in2, input, 8, lane 2 parallel data.
- write1, input, 1, push in1 into FIFO 1.
- write2, input, 1, push in2 into FIFO 2.
- out1, output, 1, lane 1 serial bit.
- out2, output, 1, lane 2 serial bit.
- valid1, output, 1, high while out1 carries a data-byte bit.
- valid2, output, 1, high while out2 carries a data-byte bit.
- almost_full_f1, output, 1, FIFO 1 count >= ALMOST_FULL_TH.
- almost_full_f2, output, 1, FIFO 2 count >= ALMOST_FULL_TH.
- err1, output, 1, sticky overflow flag for lane 1.
- err2, output, 1, sticky overflow flag for lane 2.
- active, output, 1, high once the sync preamble is complete.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: out*=0, valid*=0, almost_full_f*=0, err*=0, active=0.
  - Internal: FIFOs empty; shift registers=0; bit_cnt=7; sync_cnt=0; state=SYNC.
  - Writes while reset=0 are ignored.
- Bit timing:
  - One shared 3-bit bit_cnt keeps both lanes byte-aligned.
  - outN = shiftN[7]. validN is registered and changes only at byte boundaries.
  - Each posedge: if bit_cnt==7, this is a boundary: load the next byte into shiftN and set bit_cnt=0. Otherwise shiftN <<= 1 and bit_cnt increments.
  - The first boundary is the first posedge after reset release.
- FSM (shared by both lanes):
  - SYNC, at each boundary:
    - If sync_cnt < SYNC_BYTES: load IDLE_BYTE on both lanes, validN=0, sync_cnt increments.
    - If sync_cnt == SYNC_BYTES: go to ACTIVE and, at this same boundary, perform the ACTIVE load below.
  - ACTIVE:
    - active=1 from that boundary edge onward.
    - At each boundary, each lane independently: if its FIFO is non-empty, pop the head into shiftN and set validN=1 for the 8 cycles. Otherwise load IDLE_BYTE and set validN=0.
    - ACTIVE has no exit except reset.
- Latency:
  - A word in the FIFO before a boundary appears on outN starting the cycle after that boundary edge.
  - Worst case from write to first bit is 8 cycles plus queued words × 8.
- FIFO rules:
  - Writes are accepted in SYNC and ACTIVE. Data is stored and sent in FIFO order.
  - Full check uses the pre-edge count. A write when count==FIFO_DEPTH is dropped and sets errN=1, even if a pop happens on the same edge. errN clears only on reset.
  - Write and pop on the same edge with 0 < count < FIFO_DEPTH: count is unchanged, order is preserved.
  - A write to an empty FIFO on a boundary edge is not popped that edge; IDLE_BYTE is loaded instead.
  - almost_full_fN is registered from count and updates on the same edge as the push/pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Lane independence: lanes differ only in FIFO contents; the FSM and bit_cnt are shared.

Test Plan:
1. Release reset at edge 0, no writes:
   - Edges 1, 9, 17, 25 load 0xBC.
   - Both lanes show 10111100 repeated, valid*=0.
   - active rises at edge 33.
2. At edge 10, write1 with in1=8'hA5 and write2 with in2=8'h3C:
   - Edge 33 loads both words.
   - During cycles 34–41, out1=1,0,1,0,0,1,0,1 and out2=0,0,1,1,1,1,0,0.
   - valid1=valid2=1 for those cycles, then 0xBC with valid=0.
3. During SYNC, write 5 words 01..05 to lane 1:
   - almost_full_f1=1 after the 3rd push.
   - 5th word is dropped and err1=1.
   - Lane 1 sends 01, 02, 03, 04 on consecutive bytes from edge 33. err2=0.
4. In ACTIVE, write lane 2 only every 16 cycles:
   - Lane 2 alternates data and 0xBC bytes, with valid2 toggling on byte boundaries.
   - Lane 1 sends only 0xBC.
5. Assert reset mid-byte (bit_cnt=3):
   - All outputs go to 0 immediately and FIFO contents are lost.
   - After release, the full 4-byte preamble repeats before active=1.
6. With count=1 in ACTIVE, write on a boundary edge:
   - Pop and push happen on the same edge; count stays 1.
   - The popped word is sent first and the new word on the next byte.
